mul_seq_nbit: RTL and testbench

- Parametrised sequential shift-add multiplier; successor to the 4-bit combinational multiplier used behind the switch/7-segment lab top.
- Operands are captured on a start pulse; the product is computed over WIDTH iteration cycles, then registered and flagged with a one-cycle done pulse.
- Supports signed (two's complement) and unsigned modes.
- Sits between the switch/operand registers and the display packer; the product port feeds the display number directly.

---
 rtl/mul_seq_nbit.sv | 60 ++++++
 tb/tb_mul_seq_nbit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: sequential shift-add multiplier, signed or unsigned, WIDTH cycles per product
module mul_seq_nbit #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mplier, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic neg;
  assign mag_a = (signed_mode & a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_mode & b[WIDTH-1]) ? -b : b;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (cnt == '0 ? FIN : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      neg <= 1'b0;
      done <= 1'b0;
      product <= '0;
    end else begin
      done <= state == FIN;
      if (state == IDLE && start) begin
        neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        mcand <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        acc <= '0;
        cnt <= CW'(WIDTH - 1);
      end
      if (state == CALC) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CW'(1);
      end
      if (state == FIN) product <= neg ? -acc : acc;
    end
  end
endmodule

// File: tb/tb_mul_seq_nbit.sv
// tb_mul_seq_nbit: vector table, corner sequences and random checks for WIDTH=4 and WIDTH=8
module tb_mul_seq_nbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s4 = 1'b0, sm4 = 1'b0, busy4, done4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;
  logic s8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  mul_seq_nbit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(s4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(p4));
  mul_seq_nbit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8));

  typedef struct {
    logic       sm;
    logic [7:0] a, b;
    logic [15:0] exp;
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b);
    longint sa = longint'(a), sb = longint'(b), mask;
    if (sm && a[w-1]) sa -= (longint'(1) << w);
    if (sm && b[w-1]) sb -= (longint'(1) << w);
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'((sa * sb) & mask);
  endfunction

  task automatic op(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b,
                    input logic [15:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    if (w == 4) begin s4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0]; end
    else begin s8 = 1'b1; sm8 = sm; a8 = a; b8 = b; end
    @(posedge clk); #1;
    s4 = 1'b0; s8 = 1'b0;
    chk({name, "_busy"}, 32'(w == 4 ? busy4 : busy8), 32'd1);
    while (n < 40 && !(w == 4 ? done4 : done8)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(w + 1));
    chk({name, "_product"}, 32'(w == 4 ? {8'h00, p4} : p8), 32'(exp));
    @(posedge clk); #1;
    chk({name, "_done_drop"}, 32'(w == 4 ? done4 : done8), 32'd0);
  endtask

  initial begin
    vec_t vt[$];
    int dn, dt[$];
    logic [7:0] pr;
    logic [7:0] ra, rb;
    logic rs;
    vt.push_back('{1'b0, 8'h0F, 8'h0F, 16'h00E1, "u15x15"});
    vt.push_back('{1'b1, 8'h08, 8'h08, 16'h0040, "s_m8xm8"});
    vt.push_back('{1'b1, 8'h0D, 8'h05, 16'h00F1, "s_m3x5"});
    vt.push_back('{1'b0, 8'h0D, 8'h05, 16'h0041, "u13x5"});
    vt.push_back('{1'b0, 8'h00, 8'h09, 16'h0000, "u0x9"});
    vt.push_back('{1'b1, 8'h0F, 8'h00, 16'h0000, "s_m1x0"});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_p4", 32'(p4), 32'd0);
    chk("rst_p8", 32'(p8), 32'd0);
    rst_n = 1'b1;
    foreach (vt[i]) op(4, vt[i].sm, vt[i].a, vt[i].b, vt[i].exp, vt[i].name);
    op(4, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "hold_pre");
    repeat (4) @(posedge clk);
    #1;
    chk("hold_product", 32'(p4), 32'h00E1);
    chk("hold_busy", 32'(busy4), 32'd0);
    // a second start while busy must be ignored, as must operand churn
    @(negedge clk);
    s4 = 1'b1; sm4 = 1'b0; a4 = 4'd3; b4 = 4'd5;
    @(posedge clk); #1;
    s4 = 1'b0;
    dn = 0; pr = '0;
    for (int c = 1; c <= 12; c++) begin
      a4 = (c == 2) ? 4'd7 : 4'($urandom);
      b4 = (c == 2) ? 4'd7 : 4'($urandom);
      sm4 = 1'($urandom);
      s4 = (c == 2);
      @(posedge clk); #1;
      if (done4) begin dn++; pr = p4; end
    end
    s4 = 1'b0;
    chk("ign_done_count", 32'(dn), 32'd1);
    chk("ign_product", 32'(pr), 32'd15);
    // continuous start: one product every WIDTH+2 cycles
    @(negedge clk);
    s4 = 1'b1; sm4 = 1'b0; a4 = 4'd2; b4 = 4'd3;
    @(posedge clk); #1;
    dn = 0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 17) s4 = 1'b0;
      if (done4) begin
        dt.push_back(i);
        chk("b2b_product", 32'(p4), 32'd6);
      end
    end
    chk("b2b_count", 32'(dt.size()), 32'd3);
    if (dt.size() == 3) begin
      chk("b2b_first", 32'(dt[0]), 32'd5);
      chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd6);
      chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd6);
    end
    repeat (8) @(posedge clk);
    // reset on the third CALC cycle aborts and clears product
    @(negedge clk);
    s4 = 1'b1; sm4 = 1'b0; a4 = 4'd9; b4 = 4'd9;
    @(posedge clk); #1;
    s4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_product", 32'(p4), 32'd0);
    dn = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_product_held", 32'(p4), 32'd0);
    op(8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u255x255");
    op(8, 1'b1, 8'h80, 8'h7F, 16'hC080, "w8_s_m128x127");
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rs = 1'($urandom);
      op(4, rs, ra, rb, model(4, rs, ra, rb), "rand4");
    end
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      op(8, rs, ra, rb, model(8, rs, ra, rb), "rand8");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
